sd_cmd_phy: RTL and testbench
=============================

Name: sd_cmd_phy

Overview:
Native-mode SD CMD-line engine, directly downstream of the SD controller FSM. Accepts one command (index + argument) per handshake and generates the SD clock. Serialises the 48-bit command frame with CRC7, then captures and checks an optional short (48-bit) or long (136-bit) response. Reports payload plus timeout/CRC/framing status back to the controller.

Parameters:
TIMEOUT_CYC, 64, max sd_clk cycles from command end bit to response start bit (NCR).
GAP_CYC, 8, sd_clk cycles of idle CMD after response or timeout before ready (NCC).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clk_div  in  8  sd_clk half-period minus 1, in clk cycles
clk_en  in  1  1 = sd_clk toggles; 0 = sd_clk parked low at next low phase
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, accepts command
cmd_index  in  6  command index
cmd_arg  in  32  command argument
resp_type  in  2  0 none, 1 short+CRC, 2 long (R2), 3 short no CRC (R3)
resp_valid  out  1  one-clk pulse: transaction finished
resp_index  out  6  short: response bits 45:40; long: 6'h3F
resp_data  out  128  short: [31:0] = bits 39:8, rest 0; long: bits 127:0 as received
resp_timeout  out  1  no start bit within TIMEOUT_CYC
resp_crc_err  out  1  CRC7 mismatch
resp_end_err  out  1  end bit was 0
sd_clk  out  1  SD clock
sd_cmd_out  out  1  CMD drive value
sd_cmd_oe  out  1  CMD output enable
sd_cmd_in  in  1  CMD sampled value (already synchronised)

Behaviour:
- Reset (reset low, async): state IDLE; cmd_ready 1; resp_valid 0; all status 0; resp_data/resp_index 0; sd_clk 0; sd_cmd_out 1; sd_cmd_oe 0; divider counter 0.
- Divider: counter counts 0..clk_div; at terminal count sd_clk toggles. rise_tick/fall_tick are single-clk strobes. clk_div is sampled only at a toggle. With clk_en 0, sd_clk stops after its next falling edge; the FSM freezes, since it advances only on ticks.
- CMD driven/changed on fall_tick; sampled on rise_tick.
- Handshake: accept on cmd_valid && cmd_ready; cmd_ready drops the next clk. Index, arg and resp_type are latched at acceptance.
- Frame: 0,1,index[5:0],arg[31:0],CRC7[6:0],1, MSB first. CRC7 polynomial x^7+x^3+1, init 0, computed serially over the first 40 bits.
- IDLE: oe 0, out 1. On accept go to SEND.
- SEND: oe 1; 48 bits on 48 successive fall_ticks. On the fall_tick after the end bit: oe 0; go to WAIT (resp_type != 0) or GAP (resp_type 0).
- WAIT: counts rise_ticks. sd_cmd_in 0 on a rise_tick → RECV, with that start bit counted as bit 47/135. Count reaching TIMEOUT_CYC → set resp_timeout, go to GAP.
- RECV: shift 47 (short) or 135 (long) further bits. CRC7 is checked over bits 47..8 (short, type 1) or bits 127..8 (long); type 3 skips the CRC check. resp_end_err is set if the last bit is 0. Latch outputs, then GAP.
- GAP: GAP_CYC rise_ticks with oe 0, then pulse resp_valid for 1 clk and go to IDLE. cmd_ready returns 1 in the same clk as the pulse.
- Status and resp_* hold until the next acceptance, then clear to 0.
- cmd_valid while busy is ignored.
- Reset mid-transfer aborts immediately, with no resp_valid.

Decomposition:
- Shared package sd_pkg: resp_type enum (RESP_NONE, RESP_SHORT, RESP_LONG, RESP_SHORT_NOCRC), frame length constants 48/136, CRC7 polynomial constant, FSM state enum.
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit inputs. It is instanced twice, once for TX and once for RX.

Test Plan:
- CMD0, arg 0, resp_type 0, clk_div 0 → CMD bits 0x40_00000000_95; resp_valid after 48+8 sd_clk cycles; all status 0.
- CMD8, arg 0x000001AA, type 1; model replies 0x08_000001AA_13 after 2 cycles (CRC7 0x09, end bit 1) → resp_index 8, resp_data[31:0] 0x1AA, no errors. Sent frame must be 0x48_000001AA_87.
- CMD8, model silent → resp_timeout 1 after exactly 64 rise_ticks in WAIT, then 8 gap cycles, then resp_valid.
- Short response with one corrupted CRC bit → resp_crc_err 1. Same response as type 3 → crc_err 0. End bit 0 → resp_end_err 1.
- CMD2, type 2; model sends 136-bit R2 with a valid CID CRC → resp_data equals the sent bits 127:0; resp_index 0x3F; no errors.
- clk_div 124 then 0, with clk_en toggled mid-SEND → sd_clk period 250 clks then 2; frame bits intact. Reset asserted mid-RECV → outputs at reset values, no resp_valid.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD CMD-line engine.
package sd_pkg;
  typedef enum logic [1:0] {RESP_NONE, RESP_SHORT, RESP_LONG, RESP_SHORT_NOCRC} resp_type_e;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_e;
  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN = 136;
  localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB first, synchronous clear.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic fb;
  assign fb = din ^ crc[6];
  always_ff @(posedge clk or negedge reset)
    if (!reset) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
endmodule

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD-line engine; sends a CRC7 command frame and captures the response.
module sd_cmd_phy
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   clk_div,
  input  logic         clk_en,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         resp_valid,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data,
  output logic         resp_timeout,
  output logic         resp_crc_err,
  output logic         resp_end_err,
  output logic         sd_clk,
  output logic         sd_cmd_out,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_in
);
  logic [7:0] div_cnt, div_q;
  logic run, tc, rise_tick, fall_tick;
  assign run = sd_clk | clk_en;
  assign tc = div_cnt == div_q;
  assign rise_tick = run & tc & ~sd_clk;
  assign fall_tick = run & tc & sd_clk;
  // A parked clock only stops in its low phase; the high phase always completes.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_cnt <= '0;
      div_q <= '0;
      sd_clk <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
    end else if (tc) begin
      div_cnt <= '0;
      div_q <= clk_div;
      sd_clk <= ~sd_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  state_e state;
  resp_type_e rtype;
  logic [39:0] tx_sr;
  logic [126:0] rx_sr;
  logic [127:0] rx_full;
  logic [15:0] cnt, last;
  logic [6:0] tx_crc, rx_crc;
  logic [2:0] crc_idx;
  logic accept, is_long, crc_range, tx_en, rx_en;
  assign accept = cmd_valid & cmd_ready & (state == IDLE);
  assign is_long = rtype == RESP_LONG;
  assign last = is_long ? 16'(LONG_LEN - 1) : 16'(SHORT_LEN - 1);
  assign rx_full = {rx_sr, sd_cmd_in};
  assign crc_idx = 3'(16'd46 - cnt);
  // Short CRC covers the first 40 received bits; long CRC skips the 8-bit header.
  assign crc_range = is_long ? (cnt >= 16'd8 && cnt < 16'd128) : (cnt < 16'd40);
  assign tx_en = fall_tick & (state == SEND) & (cnt < 16'd40);
  assign rx_en = rise_tick & (((state == WAIT) & ~sd_cmd_in & ~is_long) | ((state == RECV) & crc_range));
  sd_crc7 u_tx_crc (.clk(clk), .reset(reset), .clr(accept), .en(tx_en), .din(tx_sr[39]), .crc(tx_crc));
  sd_crc7 u_rx_crc (.clk(clk), .reset(reset), .clr(accept), .en(rx_en), .din(sd_cmd_in), .crc(rx_crc));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rtype <= RESP_NONE;
      cmd_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_index <= '0;
      resp_data <= '0;
      resp_timeout <= 1'b0;
      resp_crc_err <= 1'b0;
      resp_end_err <= 1'b0;
      sd_cmd_out <= 1'b1;
      sd_cmd_oe <= 1'b0;
      cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= SEND;
          cmd_ready <= 1'b0;
          rtype <= resp_type_e'(resp_type);
          tx_sr <= {2'b01, cmd_index, cmd_arg};
          cnt <= '0;
          resp_index <= '0;
          resp_data <= '0;
          resp_timeout <= 1'b0;
          resp_crc_err <= 1'b0;
          resp_end_err <= 1'b0;
        end
        SEND: if (fall_tick) begin
          if (cnt == 16'(SHORT_LEN)) begin
            sd_cmd_oe <= 1'b0;
            sd_cmd_out <= 1'b1;
            cnt <= '0;
            state <= (rtype == RESP_NONE) ? GAP : WAIT;
          end else begin
            sd_cmd_oe <= 1'b1;
            sd_cmd_out <= cnt < 16'd40 ? tx_sr[39] : cnt < 16'd47 ? tx_crc[crc_idx] : 1'b1;
            tx_sr <= tx_sr << 1;
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: if (rise_tick) begin
          if (!sd_cmd_in) begin
            state <= RECV;
            rx_sr <= rx_full[126:0];
            cnt <= 16'd1;
          end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
            resp_timeout <= 1'b1;
            state <= GAP;
            cnt <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RECV: if (rise_tick) begin
          rx_sr <= rx_full[126:0];
          if (cnt == last) begin
            resp_end_err <= ~sd_cmd_in;
            resp_crc_err <= (rtype != RESP_SHORT_NOCRC) && (rx_sr[6:0] != rx_crc);
            resp_index <= is_long ? 6'h3F : rx_full[45:40];
            resp_data <= is_long ? rx_full : {96'h0, rx_full[39:8]};
            state <= GAP;
            cnt <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: if (rise_tick) begin
          if (cnt == 16'(GAP_CYC - 1)) begin
            resp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb_sd_cmd_phy: directed self-checking bench with a simple card response model.
module tb_sd_cmd_phy;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic clk_en = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [5:0] cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [1:0] resp_type = 2'd0;
  logic resp_valid;
  logic [5:0] resp_index;
  logic [127:0] resp_data;
  logic resp_timeout, resp_crc_err, resp_end_err;
  logic sd_clk, sd_cmd_out, sd_cmd_oe;
  logic sd_cmd_in = 1'b1;
  int passed = 0;
  int total = 0;

  sd_cmd_phy dut (
    .clk(clk), .reset(reset), .clk_div(clk_div), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_type(resp_type), .resp_valid(resp_valid),
    .resp_index(resp_index), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .resp_crc_err(resp_crc_err), .resp_end_err(resp_end_err), .sd_clk(sd_clk),
    .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_in(sd_cmd_in)
  );

  always #5 clk = ~clk;

  // Frame capture on the card side, plus rising edges seen after the command ended.
  logic [47:0] tx_cap = '0;
  int tx_bits = 0;
  int post_rises = 0;
  bit tx_done = 0;
  always @(posedge sd_clk) begin
    if (sd_cmd_oe) begin
      tx_cap = {tx_cap[46:0], sd_cmd_out};
      tx_bits++;
      if (tx_bits == 48) tx_done = 1;
    end else if (tx_done) post_rises++;
  end

  logic [135:0] rbits = '0;
  int rlen = 0;
  int rdly = 0;
  int rpos = 0;
  bit rarm = 0;
  always @(negedge sd_clk) begin
    if (rarm && tx_done) begin
      if (rdly > 0) rdly--;
      else if (rpos < rlen) begin
        sd_cmd_in = rbits[rlen-1-rpos];
        rpos++;
      end else begin
        sd_cmd_in = 1'b1;
        rarm = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic arm(input logic [135:0] bits, input int len, input int dly);
    rbits = bits;
    rlen = len;
    rdly = dly;
    rpos = 0;
    rarm = 1;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    int i;
    for (i = 0; i < 2000 && !cmd_ready; i++) @(posedge clk);
    tx_bits = 0;
    tx_done = 0;
    post_rises = 0;
    tx_cap = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg = arg;
    resp_type = typ;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(posedge clk);
      #1 seen = resp_valid;
    end
    chk({tag, "_done"}, 128'(seen), 128'(1));
  endtask

  task automatic measure(output int p);
    logic prev;
    bit got;
    p = 0;
    got = 0;
    prev = sd_clk;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (sd_clk && !prev) got = 1;
      prev = sd_clk;
    end
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      p++;
      if (sd_clk && !prev) got = 1;
      prev = sd_clk;
    end
  endtask

  logic [119:0] cid;
  logic [6:0] cid_crc;
  int per, held, pulses;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_valid", 128'(resp_valid), 128'(0));
    chk("rst_pins", 128'({sd_clk, sd_cmd_out, sd_cmd_oe}), 128'(3'b010));
    chk("rst_resp", 128'({resp_index, resp_timeout, resp_crc_err, resp_end_err}), 128'(0));
    chk("rst_data", resp_data, 128'(0));
    @(negedge clk) reset = 1'b1;

    issue(6'd0, 32'd0, 2'd0);
    #1 chk("cmd0_ready_drop", 128'(cmd_ready), 128'(0));
    wait_done("cmd0");
    chk("cmd0_frame", 128'(tx_cap), 128'(48'h40_00000000_95));
    chk("cmd0_bits", 128'(tx_bits), 128'(48));
    chk("cmd0_gap", 128'(post_rises), 128'(8));
    chk("cmd0_ready", 128'(cmd_ready), 128'(1));
    chk("cmd0_status", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(0));
    @(posedge clk);
    #1 chk("cmd0_pulse", 128'(resp_valid), 128'(0));

    arm(136'h08_000001AA_13, 48, 2);
    issue(6'd8, 32'h1AA, 2'd1);
    wait_done("cmd8");
    chk("cmd8_frame", 128'(tx_cap), 128'(48'h48_000001AA_87));
    chk("cmd8_index", 128'(resp_index), 128'(8));
    chk("cmd8_data", resp_data, 128'(32'h1AA));
    chk("cmd8_status", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(0));

    issue(6'd8, 32'h1AA, 2'd1);
    #1 chk("clear_data", resp_data, 128'(0));
    chk("clear_index", 128'(resp_index), 128'(0));
    wait_done("tmo");
    chk("tmo_flag", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(3'b100));
    chk("tmo_rises", 128'(post_rises), 128'(72));

    arm(136'h08_000001AA_13 ^ 136'h8, 48, 2);
    issue(6'd8, 32'h1AA, 2'd1);
    wait_done("crcbad");
    chk("crcbad_status", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(3'b010));
    chk("crcbad_index", 128'(resp_index), 128'(8));

    arm(136'h08_000001AA_13 ^ 136'h8, 48, 2);
    issue(6'd8, 32'h1AA, 2'd3);
    wait_done("r3");
    chk("r3_status", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(0));
    chk("r3_data", resp_data, 128'(32'h1AA));

    arm(136'h08_000001AA_12, 48, 2);
    issue(6'd8, 32'h1AA, 2'd1);
    wait_done("endbad");
    chk("endbad_status", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(3'b001));

    cid = 120'h03_5344_5344_3136_4780_1234_5678_01;
    cid_crc = crc7(cid);
    arm({8'h3F, cid, cid_crc, 1'b1}, 136, 3);
    issue(6'd2, 32'd0, 2'd2);
    wait_done("r2");
    chk("r2_frame", 128'(tx_cap), 128'(48'h42_00000000_4D));
    chk("r2_data", resp_data, {cid, cid_crc, 1'b1});
    chk("r2_index", 128'(resp_index), 128'(6'h3F));
    chk("r2_status", 128'({resp_timeout, resp_crc_err, resp_end_err}), 128'(0));

    clk_div = 8'd124;
    measure(per);
    measure(per);
    chk("period_250", 128'(per), 128'(250));
    clk_div = 8'd0;
    measure(per);
    measure(per);
    chk("period_2", 128'(per), 128'(2));

    issue(6'd0, 32'd0, 2'd0);
    for (int i = 0; i < 2000 && tx_bits < 20; i++) @(posedge clk);
    clk_en = 1'b0;
    repeat (10) @(posedge clk);
    #1 held = tx_bits;
    repeat (40) @(posedge clk);
    #1 chk("park_low", 128'(sd_clk), 128'(0));
    chk("park_frozen", 128'(tx_bits), 128'(held));
    clk_en = 1'b1;
    wait_done("park");
    chk("park_frame", 128'(tx_cap), 128'(48'h40_00000000_95));

    arm(136'h08_000001AA_13, 48, 2);
    issue(6'd8, 32'h1AA, 2'd1);
    for (int i = 0; i < 2000 && rpos < 10; i++) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk("abort_ready", 128'(cmd_ready), 128'(1));
    chk("abort_pins", 128'({sd_clk, sd_cmd_out, sd_cmd_oe, resp_valid}), 128'(4'b0100));
    rarm = 0;
    sd_cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1 if (resp_valid) pulses++;
    end
    chk("abort_no_valid", 128'(pulses), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
